pipeline_stall_ctrl: RTL and testbench
======================================

# pipeline_stall_ctrl

Central stall/flush sequencer for the 5-stage RISC-V pipeline. It merges the load-use stall from hazard detection, I-cache and D-cache wait handshakes, and EX-stage branch/jump redirects into per-stage write enables and flushes. While the front end is stalled, it holds a redirect pending and replays it when fetch resumes. It also maintains saturating stall and flush counters for performance monitoring.

## Interface
Parameters:
- CNT_W, 16, width of each performance counter
- ADDR_W, 32, PC / redirect target width

Ports:
- clk  in  1  pipeline clock, all state updates on rising edge
- rst_n  in  1  reset, asynchronous, active-low (one clock; reset is asynchronous and active-low)
- load_use  in  1  load-use stall request from hazard detection
- icache_stall  in  1  I-cache miss in progress, fetched instruction not valid
- dcache_stall  in  1  D-cache miss in progress, MEM stage cannot complete
- redirect  in  1  taken branch/jump resolved in EX
- redirect_target  in  ADDR_W  target PC accompanying redirect
- cnt_clr  in  1  synchronous clear of both counters
- pc_write  out  1  PC register enable
- pc_redirect  out  1  select pc_target as next PC
- pc_target  out  ADDR_W  next-PC target when pc_redirect=1
- ifid_write  out  1  IF/ID enable
- ifid_flush  out  1  IF/ID to NOP, overrides ifid_write
- idex_write  out  1  ID/EX enable
- idex_flush  out  1  ID/EX to bubble (controls zeroed)
- exmem_write  out  1  EX/MEM enable
- memwb_write  out  1  MEM/WB enable
- stall_cnt  out  CNT_W  cycles with pc_write=0 (saturating)
- flush_cnt  out  CNT_W  redirects taken (saturating)

## Operation
- States: RUN, IWAIT (I-cache stall, no pending redirect), IWAIT_R (I-cache stall, pending redirect held in pend_tgt).
- Default (RUN, no requests): all *_write=1, flushes=0, pc_redirect=0, pc_target=redirect_target.
- Priority, highest first: dcache_stall > icache_stall / pending redirect > redirect > load_use.
- dcache_stall=1, any state: all five *_write=0, all flushes=0, pc_redirect=0; state and pend_tgt unchanged. The redirect remains held because EX is frozen.
- icache_stall=1 (dcache_stall=0):
  - pc_write=0, ifid_write=0, idex_flush=1; back end advances.
  - If redirect=1: ifid_flush=1, pend_tgt<=redirect_target, next state IWAIT_R, flush_cnt increments.
  - Otherwise go to IWAIT; IWAIT_R stays IWAIT_R.
- icache_stall falls in IWAIT_R:
  - pc_write=1, pc_redirect=1, pc_target=pend_tgt, ifid_flush=1, idex_flush=1; go to RUN.
  - A new redirect in the same cycle wins: pc_target=redirect_target, flush_cnt increments.
- icache_stall falls in IWAIT: resume as default, go to RUN.
- redirect in RUN (no cache stalls): pc_write=1, pc_redirect=1, pc_target=redirect_target, ifid_flush=1, idex_flush=1, flush_cnt increments. A coincident load_use is ignored because it is wrong-path.
- load_use in RUN only: pc_write=0, ifid_write=0, idex_flush=1, other writes=1.
- Counters:
  - Saturate at all-ones; no wrap.
  - cnt_clr has priority over increment in the same cycle.
  - flush_cnt counts each distinct redirect once, including while dcache_stall holds it: count on the first cycle it is accepted (not frozen).

## Timing
- All outputs are combinational from current state, pend_tgt and inputs (Mealy), valid in the same cycle. Latency to pipeline enables is 0 cycles.
- state, pend_tgt and the counters update on the rising clk edge.
- Async reset (rst_n=0): state=RUN, pend_tgt=0, stall_cnt=0, flush_cnt=0. While rst_n=0: all *_write=0, all flushes=0, pc_redirect=0, pc_target=0.
- Reset released mid-miss: the controller starts in RUN and obeys the current icache_stall/dcache_stall levels next cycle; no pending redirect survives reset.
- Redirect replay after an I-cache stall costs exactly one extra cycle versus RUN: the resume cycle carries the redirect.
- Inputs must be glitch-free by the clock edge; no internal synchronisation.

## Test plan
- load_use=1 for 1 cycle in RUN -> pc_write=0, ifid_write=0, idex_flush=1 that cycle; stall_cnt 0->1; next cycle all writes=1.
- redirect=1, target=0x0000_0040 in RUN with load_use=1 -> pc_redirect=1, pc_target=0x40, ifid_flush=idex_flush=1, pc_write=1; flush_cnt=1, stall_cnt=0.
- icache_stall=1 for 4 cycles with redirect=1, target=0x100 in cycle 1 -> state IWAIT_R, pc_write=0 for 4 cycles. On the fall cycle: pc_redirect=1, pc_target=0x100, ifid_flush=1. stall_cnt=4, flush_cnt=1.
- dcache_stall=1 for 3 cycles with redirect held high throughout -> all writes 0, flush_cnt unchanged. On release: redirect taken once, flush_cnt +1.
- Preload stall_cnt to saturation (CNT_W=4 build, 20 load_use cycles) -> stall_cnt sticks at 0xF; cnt_clr with load_use same cycle -> 0.
- rst_n low during IWAIT_R -> all outputs 0 immediately; after release with icache_stall=0, the pending target is lost and state is RUN.

Source files
------------

// File: rtl/pipeline_stall_ctrl.sv
// Central stall/flush sequencer for the 5-stage pipeline: merges cache waits,
// load-use stalls and EX redirects into per-stage enables, with perf counters.
module pipeline_stall_ctrl #(
  parameter int unsigned CNT_W  = 16,
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_use,
  input  logic              icache_stall,
  input  logic              dcache_stall,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_target,
  input  logic              cnt_clr,
  output logic              pc_write,
  output logic              pc_redirect,
  output logic [ADDR_W-1:0] pc_target,
  output logic              ifid_write,
  output logic              ifid_flush,
  output logic              idex_write,
  output logic              idex_flush,
  output logic              exmem_write,
  output logic              memwb_write,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    IWAIT   = 2'd1,
    IWAIT_R = 2'd2
  } state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] pend_tgt, pend_nxt;
  logic              flush_inc;
  logic              stall_inc;

  // State and pending redirect target
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= RUN;
      pend_tgt <= '0;
    end else begin
      state    <= state_nxt;
      pend_tgt <= pend_nxt;
    end
  end

  // Priority: dcache > icache / pending replay > redirect > load_use
  always_comb begin
    state_nxt   = state;
    pend_nxt    = pend_tgt;
    flush_inc   = 1'b0;
    pc_write    = 1'b1;
    pc_redirect = 1'b0;
    pc_target   = redirect_target;
    ifid_write  = 1'b1;
    ifid_flush  = 1'b0;
    idex_write  = 1'b1;
    idex_flush  = 1'b0;
    exmem_write = 1'b1;
    memwb_write = 1'b1;

    if (!rst_n) begin
      pc_write    = 1'b0;
      pc_target   = '0;
      ifid_write  = 1'b0;
      idex_write  = 1'b0;
      exmem_write = 1'b0;
      memwb_write = 1'b0;
      state_nxt   = RUN;
    end else if (dcache_stall) begin
      // Whole pipe frozen; EX keeps presenting any redirect until release
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      idex_write  = 1'b0;
      exmem_write = 1'b0;
      memwb_write = 1'b0;
    end else if (icache_stall) begin
      pc_write   = 1'b0;
      ifid_write = 1'b0;
      idex_flush = 1'b1;
      if (redirect) begin
        ifid_flush = 1'b1;
        pend_nxt   = redirect_target;
        flush_inc  = 1'b1;
        state_nxt  = IWAIT_R;
      end else if (state != IWAIT_R) begin
        state_nxt = IWAIT;
      end
    end else if (redirect || state == IWAIT_R) begin
      // A fresh redirect is younger-resolved than the held one and wins
      pc_redirect = 1'b1;
      pc_target   = redirect ? redirect_target : pend_tgt;
      ifid_flush  = 1'b1;
      idex_flush  = 1'b1;
      flush_inc   = redirect;
      state_nxt   = RUN;
    end else if (load_use) begin
      pc_write   = 1'b0;
      ifid_write = 1'b0;
      idex_flush = 1'b1;
      state_nxt  = RUN;
    end else begin
      state_nxt = RUN;
    end
  end

  assign stall_inc = ~pc_write;

  // Saturating performance counters, clear wins over increment
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else if (cnt_clr) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall_inc && !(&stall_cnt)) stall_cnt <= stall_cnt + CNT_W'(1);
      if (flush_inc && !(&flush_cnt)) flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Table-driven bench for pipeline_stall_ctrl (CNT_W=4 build); counter
// expectations travel through a scoreboard queue to the following clock edge.
module tb_pipeline_stall_ctrl;

  localparam int unsigned CNT_W  = 4;
  localparam int unsigned ADDR_W = 32;

  // ctl bit order: pc_write pc_redirect ifid_write ifid_flush idex_write idex_flush exmem_write memwb_write
  localparam logic [7:0] C_DEF  = 8'hAB;
  localparam logic [7:0] C_HOLD = 8'h0F;
  localparam logic [7:0] C_RDIR = 8'hFF;
  localparam logic [7:0] C_ICRD = 8'h1F;
  localparam logic [7:0] C_ZERO = 8'h00;

  typedef struct {
    string       name;
    logic        lu, ic, dc, rd, clr;
    logic [31:0] tgt;
    logic [7:0]  ctl;
    logic [31:0] exp_tgt;
    logic [3:0]  sc, fc;
  } vec_t;

  typedef struct {
    string      name;
    logic [3:0] sc, fc;
  } cnt_exp_t;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              load_use, icache_stall, dcache_stall, redirect, cnt_clr;
  logic [ADDR_W-1:0] redirect_target;
  logic              pc_write, pc_redirect, ifid_write, ifid_flush;
  logic              idex_write, idex_flush, exmem_write, memwb_write;
  logic [ADDR_W-1:0] pc_target;
  logic [CNT_W-1:0]  stall_cnt, flush_cnt;

  int total = 0;
  int bad   = 0;
  cnt_exp_t sb[$];
  vec_t     tbl[26];

  pipeline_stall_ctrl #(.CNT_W(CNT_W), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst_n(rst_n), .load_use(load_use), .icache_stall(icache_stall),
    .dcache_stall(dcache_stall), .redirect(redirect), .redirect_target(redirect_target),
    .cnt_clr(cnt_clr), .pc_write(pc_write), .pc_redirect(pc_redirect), .pc_target(pc_target),
    .ifid_write(ifid_write), .ifid_flush(ifid_flush), .idex_write(idex_write),
    .idex_flush(idex_flush), .exmem_write(exmem_write), .memwb_write(memwb_write),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(string name, logic lu, logic ic, logic dc, logic rd,
                              logic clr, logic [31:0] tgt, logic [7:0] ctl,
                              logic [31:0] exp_tgt, logic [3:0] sc, logic [3:0] fc);
    vec_t v;
    v.name = name; v.lu = lu; v.ic = ic; v.dc = dc; v.rd = rd; v.clr = clr;
    v.tgt = tgt; v.ctl = ctl; v.exp_tgt = exp_tgt; v.sc = sc; v.fc = fc;
    return v;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] ctl_now();
    return {pc_write, pc_redirect, ifid_write, ifid_flush,
            idex_write, idex_flush, exmem_write, memwb_write};
  endfunction

  // Called at posedge+1: drive, check Mealy outputs, then counters after the edge
  task automatic step(vec_t v);
    cnt_exp_t e;
    load_use = v.lu; icache_stall = v.ic; dcache_stall = v.dc;
    redirect = v.rd; cnt_clr = v.clr; redirect_target = v.tgt;
    #1;
    chk({v.name, ".ctl"}, 32'(ctl_now()), 32'(v.ctl));
    chk({v.name, ".tgt"}, pc_target, v.exp_tgt);
    e.name = v.name; e.sc = v.sc; e.fc = v.fc;
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk({e.name, ".stall_cnt"}, 32'(stall_cnt), 32'(e.sc));
    chk({e.name, ".flush_cnt"}, 32'(flush_cnt), 32'(e.fc));
  endtask

  initial begin
    tbl[0]  = mk("idle",       0,0,0,0,0, 32'h1234, C_DEF,  32'h1234, 0, 0);
    tbl[1]  = mk("lu",         1,0,0,0,0, 32'h1234, C_HOLD, 32'h1234, 1, 0);
    tbl[2]  = mk("lu_after",   0,0,0,0,0, 32'h1234, C_DEF,  32'h1234, 1, 0);
    tbl[3]  = mk("clr0",       0,0,0,0,1, 32'h1234, C_DEF,  32'h1234, 0, 0);
    tbl[4]  = mk("rd_lu",      1,0,0,1,0, 32'h40,   C_RDIR, 32'h40,   0, 1);
    tbl[5]  = mk("clr1",       0,0,0,0,1, 32'h40,   C_DEF,  32'h40,   0, 0);
    tbl[6]  = mk("ic_rd",      0,1,0,1,0, 32'h100,  C_ICRD, 32'h100,  1, 1);
    tbl[7]  = mk("ic_hold1",   0,1,0,0,0, 32'h222,  C_HOLD, 32'h222,  2, 1);
    tbl[8]  = mk("ic_hold2",   0,1,0,0,0, 32'h222,  C_HOLD, 32'h222,  3, 1);
    tbl[9]  = mk("ic_hold3",   0,1,0,0,0, 32'h222,  C_HOLD, 32'h222,  4, 1);
    tbl[10] = mk("ic_replay",  0,0,0,0,0, 32'h333,  C_RDIR, 32'h100,  4, 1);
    tbl[11] = mk("post_rply",  0,0,0,0,0, 32'h333,  C_DEF,  32'h333,  4, 1);
    tbl[12] = mk("clr2",       0,0,0,0,1, 32'h333,  C_DEF,  32'h333,  0, 0);
    tbl[13] = mk("dc_rd1",     0,0,1,1,0, 32'h80,   C_ZERO, 32'h80,   1, 0);
    tbl[14] = mk("dc_rd2",     0,0,1,1,0, 32'h80,   C_ZERO, 32'h80,   2, 0);
    tbl[15] = mk("dc_rd3",     0,0,1,1,0, 32'h80,   C_ZERO, 32'h80,   3, 0);
    tbl[16] = mk("dc_release", 0,0,0,1,0, 32'h80,   C_RDIR, 32'h80,   3, 1);
    tbl[17] = mk("idle2",      0,0,0,0,0, 32'h80,   C_DEF,  32'h80,   3, 1);
    tbl[18] = mk("ic_norm",    0,1,0,0,0, 32'h90,   C_HOLD, 32'h90,   4, 1);
    tbl[19] = mk("ic_resume",  0,0,0,0,0, 32'h90,   C_DEF,  32'h90,   4, 1);
    tbl[20] = mk("ic_rd2",     0,1,0,1,0, 32'h500,  C_ICRD, 32'h500,  5, 2);
    tbl[21] = mk("replay_new", 0,0,0,1,0, 32'h600,  C_RDIR, 32'h600,  5, 3);
    tbl[22] = mk("idle3",      0,0,0,0,0, 32'h600,  C_DEF,  32'h600,  5, 3);
    tbl[23] = mk("dc_over_ic", 1,1,1,1,0, 32'h650,  C_ZERO, 32'h650,  6, 3);
    tbl[24] = mk("idle4",      0,0,0,0,0, 32'h650,  C_DEF,  32'h650,  6, 3);
    tbl[25] = mk("clr_lu",     1,0,0,0,1, 32'h650,  C_HOLD, 32'h650,  0, 0);

    rst_n = 1'b0; load_use = 0; icache_stall = 0; dcache_stall = 0;
    redirect = 0; cnt_clr = 0; redirect_target = 32'hDEAD_BEEF;
    #2;
    chk("reset.ctl", 32'(ctl_now()), 32'(C_ZERO));
    chk("reset.tgt", pc_target, 32'h0);
    chk("reset.stall_cnt", 32'(stall_cnt), 32'h0);
    chk("reset.flush_cnt", 32'(flush_cnt), 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    foreach (tbl[i]) step(tbl[i]);

    // Flush counter saturation
    for (int i = 0; i < 17; i++)
      step(mk("fc_sat", 0,0,0,1,0, 32'(i * 4), C_RDIR, 32'(i * 4), 0,
              (i + 1 > 15) ? 4'd15 : 4'(i + 1)));
    // Stall counter saturation, then clear beats a coincident load_use
    for (int i = 0; i < 20; i++)
      step(mk("sc_sat", 1,0,0,0,0, 32'h44, C_HOLD, 32'h44,
              (i + 1 > 15) ? 4'd15 : 4'(i + 1), 4'd15));
    step(mk("sat_clr", 1,0,0,0,1, 32'h44, C_HOLD, 32'h44, 0, 0));

    // Asynchronous reset while a redirect is pending in IWAIT_R
    step(mk("pre_rst", 0,1,0,1,0, 32'h700, C_ICRD, 32'h700, 1, 1));
    icache_stall = 0; redirect = 0; redirect_target = 32'h900;
    rst_n = 1'b0;
    #1;
    chk("rst_mid.ctl", 32'(ctl_now()), 32'(C_ZERO));
    chk("rst_mid.tgt", pc_target, 32'h0);
    chk("rst_mid.stall_cnt", 32'(stall_cnt), 32'h0);
    chk("rst_mid.flush_cnt", 32'(flush_cnt), 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    step(mk("post_rst", 0,0,0,0,0, 32'h900, C_DEF, 32'h900, 0, 0));
    step(mk("post_rst_lu", 1,0,0,0,0, 32'h904, C_HOLD, 32'h904, 1, 0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
